// File: rtl/gb_mcu_pkg.sv
// ---------------------------------------------------------------------------
// gb_mcu_pkg
// Shared definitions for the Game Boy style memory controller: region
// boundaries, IO register addresses, DMA state encodings and small decode
// helpers used by gb_mcu and gb_mcu_dma.
// ---------------------------------------------------------------------------
package gb_mcu_pkg;

    localparam logic [15:0] BOOT_LIMIT     = 16'h00FF;
    localparam logic [15:0] ECHO_BASE      = 16'hE000;
    localparam logic [15:0] ECHO_LIMIT     = 16'hFDFF;
    localparam logic [15:0] ECHO_OFFSET    = 16'h2000;
    localparam logic [15:0] OAM_BASE       = 16'hFE00;
    localparam logic [15:0] OAM_LIMIT      = 16'hFE9F;
    localparam logic [15:0] UNUSABLE_LIMIT = 16'hFEFF;
    localparam logic [15:0] HRAM_BASE      = 16'hFF80;
    localparam logic [15:0] HRAM_LIMIT     = 16'hFFFE;

    localparam logic [15:0] ADDR_IF   = 16'hFF0F;
    localparam logic [15:0] ADDR_DMA  = 16'hFF46;
    localparam logic [15:0] ADDR_BOOT = 16'hFF50;
    localparam logic [15:0] ADDR_IE   = 16'hFFFF;

    // Last byte index of an OAM transfer (160 bytes).
    localparam logic [7:0] DMA_LAST       = 8'h9F;
    localparam logic [7:0] ECHO_HI        = 8'hE0;
    localparam logic [7:0] ECHO_HI_OFFSET = 8'h20;

    typedef enum logic [1:0] {
        DMA_IDLE = 2'd0,
        DMA_RD   = 2'd1,
        DMA_WR   = 2'd2
    } dmaState_t;

    typedef enum logic [2:0] {
        RGN_BOOT,
        RGN_EXT,
        RGN_UNUSABLE,
        RGN_HRAM,
        RGN_IF,
        RGN_DMA,
        RGN_BOOTREG,
        RGN_IE
    } region_t;

    // Where the second read stage takes its data from.
    typedef enum logic [1:0] {
        SEL_REG,
        SEL_EXT,
        SEL_BOOT
    } rdSel_t;

    function automatic region_t decodeRegion(input logic [15:0] addr, input logic bootEn);
        region_t rgn;
        if (addr <= BOOT_LIMIT)
            rgn = bootEn ? RGN_BOOT : RGN_EXT;
        else if (addr <= OAM_LIMIT)
            rgn = RGN_EXT;          // cartridge, VRAM, ext RAM, WRAM, echo, OAM
        else if (addr <= UNUSABLE_LIMIT)
            rgn = RGN_UNUSABLE;
        else if (addr == ADDR_IF)
            rgn = RGN_IF;
        else if (addr == ADDR_DMA)
            rgn = RGN_DMA;
        else if (addr == ADDR_BOOT)
            rgn = RGN_BOOTREG;
        else if (addr == ADDR_IE)
            rgn = RGN_IE;
        else if (addr >= HRAM_BASE && addr <= HRAM_LIMIT)
            rgn = RGN_HRAM;
        else
            rgn = RGN_EXT;          // remaining FF00-FF7F IO lives outside
        return rgn;
    endfunction

    // Echo RAM mirrors C000-DDFF.
    function automatic logic [15:0] extAddr(input logic [15:0] addr);
        return (addr >= ECHO_BASE && addr <= ECHO_LIMIT) ? addr - ECHO_OFFSET : addr;
    endfunction

    // DMA source page: every page from E0h up is folded down by 20h.
    function automatic logic [7:0] dmaSrcHi(input logic [7:0] hi);
        return (hi >= ECHO_HI) ? hi - ECHO_HI_OFFSET : hi;
    endfunction

endpackage

// File: rtl/gb_mcu_dma.sv
// ---------------------------------------------------------------------------
// gb_mcu_dma
// OAM DMA engine: copies 160 bytes from page iSrcHi (XX00-XX9F) to FE00-FE9F,
// one read cycle followed by one write cycle per byte. All outputs are
// registered; the parent muxes them onto the external bus while oActive.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   DMA_IDLE | no transfer, bus belongs to the CPU
//   DMA_RD   | oRe at source byte; data arrives next cycle
//   DMA_WR   | oWe at OAM byte with the data read in the previous cycle
//
// Ports:
//   iClock, iReset  clock, synchronous active-high reset
//   iStart          start (or restart at byte 0) a transfer
//   iSrcHi          source page as written by the CPU
//   oActive         transfer in progress
//   oAddr/oRe/oWe   external bus request
// ---------------------------------------------------------------------------
module gb_mcu_dma
    import gb_mcu_pkg::*;
(
    input  logic        iClock,
    input  logic        iReset,
    input  logic        iStart,
    input  logic [7:0]  iSrcHi,
    output logic        oActive,
    output logic [15:0] oAddr,
    output logic        oRe,
    output logic        oWe
);

    dmaState_t  state;
    logic [7:0] count;
    logic [7:0] srcHi;

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state   <= DMA_IDLE;
            count   <= 8'h00;
            srcHi   <= 8'h00;
            oActive <= 1'b0;
            oAddr   <= 16'h0000;
            oRe     <= 1'b0;
            oWe     <= 1'b0;
        end else if (iStart) begin
            state   <= DMA_RD;
            count   <= 8'h00;
            srcHi   <= dmaSrcHi(iSrcHi);
            oActive <= 1'b1;
            oAddr   <= {dmaSrcHi(iSrcHi), 8'h00};
            oRe     <= 1'b1;
            oWe     <= 1'b0;
        end else begin
            case (state)
                DMA_RD: begin
                    state <= DMA_WR;
                    oAddr <= OAM_BASE + {8'h00, count};
                    oRe   <= 1'b0;
                    oWe   <= 1'b1;
                end
                DMA_WR: begin
                    if (count == DMA_LAST) begin
                        state   <= DMA_IDLE;
                        oActive <= 1'b0;
                        oAddr   <= 16'h0000;
                        oRe     <= 1'b0;
                        oWe     <= 1'b0;
                    end else begin
                        state <= DMA_RD;
                        count <= count + 8'd1;
                        oAddr <= {srcHi, count + 8'd1};
                        oRe   <= 1'b1;
                        oWe   <= 1'b0;
                    end
                end
                default: begin
                    state   <= DMA_IDLE;
                    oActive <= 1'b0;
                    oRe     <= 1'b0;
                    oWe     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/gb_mcu.sv
// ---------------------------------------------------------------------------
// gb_mcu
// CPU-side memory controller: address decode, echo remap, boot ROM overlay,
// HRAM, IF/IE/DMA/boot-disable registers, 2-cycle read pipeline and the
// external bus mux shared with the OAM DMA engine.
//
// Ports:
//   iClock, iReset                 clock, synchronous active-high reset
//   iCpuAddr/iCpuData              CPU address and write data
//   iCpuWe/iCpuReadRequest         one-cycle write / read strobes
//   oCpuData                       registered read data
//   oExtAddr/oExtData/oExtWe/oExtRe, iExtData   external synchronous memories
//   oBootAddr/iBootData            boot ROM port
//   oDmaActive                     OAM DMA in progress
//   oIE/oIF                        interrupt enable / flag registers
// ---------------------------------------------------------------------------
module gb_mcu
    import gb_mcu_pkg::*;
(
    input  logic        iClock,
    input  logic        iReset,
    input  logic [15:0] iCpuAddr,
    input  logic [7:0]  iCpuData,
    input  logic        iCpuWe,
    input  logic        iCpuReadRequest,
    output logic [7:0]  oCpuData,
    output logic [15:0] oExtAddr,
    output logic [7:0]  oExtData,
    output logic        oExtWe,
    output logic        oExtRe,
    input  logic [7:0]  iExtData,
    output logic [7:0]  oBootAddr,
    input  logic [7:0]  iBootData,
    output logic        oDmaActive,
    output logic [7:0]  oIE,
    output logic [7:0]  oIF
);

    logic       bootEn;
    logic [7:0] regIE;
    logic [7:0] regIF;
    logic [7:0] regDma;
    logic [7:0] hram [0:126];

    logic       rdPend;
    rdSel_t     rdSel;
    logic [7:0] rdVal;

    region_t     region;
    logic [15:0] cpuExtAddr;
    logic [6:0]  hramIdx;
    logic        cpuRd;
    logic        cpuWr;
    logic        allowed;
    logic        dmaStart;

    logic        dmaActive;
    logic [15:0] dmaAddr;
    logic        dmaRe;
    logic        dmaWe;

    always_comb begin
        region     = decodeRegion(iCpuAddr, bootEn);
        cpuExtAddr = extAddr(iCpuAddr);
        hramIdx    = iCpuAddr[6:0];
        cpuWr      = iCpuWe;
        cpuRd      = iCpuReadRequest & ~iCpuWe;     // write wins over read
        // While DMA owns the bus only HRAM and the DMA register stay reachable.
        allowed    = ~dmaActive | (region == RGN_HRAM) | (region == RGN_DMA);
        dmaStart   = cpuWr & (region == RGN_DMA);
    end

    gb_mcu_dma uDma (
        .iClock  (iClock),
        .iReset  (iReset),
        .iStart  (dmaStart),
        .iSrcHi  (iCpuData),
        .oActive (dmaActive),
        .oAddr   (dmaAddr),
        .oRe     (dmaRe),
        .oWe     (dmaWe)
    );

    always_ff @(posedge iClock) begin
        if (iReset) begin
            bootEn   <= 1'b1;
            regIE    <= 8'h00;
            regIF    <= 8'h00;
            regDma   <= 8'h00;
            rdPend   <= 1'b0;
            rdSel    <= SEL_REG;
            rdVal    <= 8'h00;
            oCpuData <= 8'h00;
        end else begin
            // Second stage: external and boot data arrive one cycle after the request.
            if (rdPend) begin
                case (rdSel)
                    SEL_EXT:  oCpuData <= iExtData;
                    SEL_BOOT: oCpuData <= iBootData;
                    default:  oCpuData <= rdVal;
                endcase
            end

            // First stage: classify the request and capture internal data.
            rdPend <= cpuRd;
            if (cpuRd) begin
                rdSel <= SEL_REG;
                rdVal <= 8'hFF;
                if (allowed) begin
                    case (region)
                        RGN_BOOT:    rdSel <= SEL_BOOT;
                        RGN_EXT:     rdSel <= SEL_EXT;
                        RGN_HRAM:    rdVal <= hram[hramIdx];
                        RGN_IF:      rdVal <= {3'b111, regIF[4:0]};
                        RGN_DMA:     rdVal <= regDma;
                        RGN_BOOTREG: rdVal <= {7'h7F, ~bootEn};
                        RGN_IE:      rdVal <= regIE;
                        default:     rdVal <= 8'hFF;
                    endcase
                end
            end

            if (cpuWr && allowed) begin
                case (region)
                    RGN_IF:      regIF  <= iCpuData;
                    RGN_IE:      regIE  <= iCpuData;
                    RGN_DMA:     regDma <= iCpuData;
                    RGN_BOOTREG: if (iCpuData != 8'h00) bootEn <= 1'b0;
                    default:     ;
                endcase
            end
        end
    end

    // HRAM keeps its contents across reset.
    always_ff @(posedge iClock) begin
        if (!iReset && cpuWr && region == RGN_HRAM)
            hram[hramIdx] <= iCpuData;
    end

    // External bus mux. Reset gates the bus immediately so an aborted DMA
    // cannot issue a write during the reset cycle itself.
    always_comb begin
        oExtAddr = 16'h0000;
        oExtData = 8'h00;
        oExtWe   = 1'b0;
        oExtRe   = 1'b0;
        if (!iReset) begin
            if (dmaActive) begin
                oExtAddr = dmaAddr;
                oExtData = iExtData;
                oExtWe   = dmaWe;
                oExtRe   = dmaRe;
            end else if (cpuWr) begin
                if (region == RGN_EXT) begin
                    oExtAddr = cpuExtAddr;
                    oExtData = iCpuData;
                    oExtWe   = 1'b1;
                end
            end else if (cpuRd && region == RGN_EXT) begin
                oExtAddr = cpuExtAddr;
                oExtRe   = 1'b1;
            end
        end
    end

    assign oBootAddr  = iCpuAddr[7:0];
    assign oDmaActive = dmaActive;
    assign oIE        = regIE;
    assign oIF        = regIF;

endmodule

// File: tb/tb_gb_mcu.sv
// ---------------------------------------------------------------------------
// tb_gb_mcu
// Directed bench for gb_mcu with a 64 KB synchronous memory model and a
// boot ROM model (data = address ^ 31h). Memory is initialised to
// addr[7:0] ^ addr[15:8] ^ A5h, with OAM FE00-FE9F cleared to 00h.
// ---------------------------------------------------------------------------
module tb_gb_mcu;

    logic        iClock;
    logic        iReset;
    logic [15:0] iCpuAddr;
    logic [7:0]  iCpuData;
    logic        iCpuWe;
    logic        iCpuReadRequest;
    logic [7:0]  oCpuData;
    logic [15:0] oExtAddr;
    logic [7:0]  oExtData;
    logic        oExtWe;
    logic        oExtRe;
    logic [7:0]  iExtData;
    logic [7:0]  oBootAddr;
    logic [7:0]  iBootData;
    logic        oDmaActive;
    logic [7:0]  oIE;
    logic [7:0]  oIF;

    gb_mcu dut (
        .iClock          (iClock),
        .iReset          (iReset),
        .iCpuAddr        (iCpuAddr),
        .iCpuData        (iCpuData),
        .iCpuWe          (iCpuWe),
        .iCpuReadRequest (iCpuReadRequest),
        .oCpuData        (oCpuData),
        .oExtAddr        (oExtAddr),
        .oExtData        (oExtData),
        .oExtWe          (oExtWe),
        .oExtRe          (oExtRe),
        .iExtData        (iExtData),
        .oBootAddr       (oBootAddr),
        .iBootData       (iBootData),
        .oDmaActive      (oDmaActive),
        .oIE             (oIE),
        .oIF             (oIF)
    );

    initial iClock = 1'b0;
    always #5 iClock = ~iClock;

    logic [7:0] mem [0:65535];
    logic       memInit;
    logic       cntClr;
    int         activeCnt;
    int         weCnt;
    int         badWe;

    int total = 0;
    int bad   = 0;

    function automatic logic [7:0] initVal(input logic [15:0] a);
        if (a >= 16'hFE00 && a <= 16'hFE9F)
            return 8'h00;
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    always @(posedge iClock) begin
        if (memInit) begin
            for (int i = 0; i < 65536; i++)
                mem[i] <= initVal(i[15:0]);
        end else if (oExtWe) begin
            mem[oExtAddr] <= oExtData;
        end
        if (oExtRe)
            iExtData <= mem[oExtAddr];
        iBootData <= oBootAddr ^ 8'h31;
        if (cntClr) begin
            activeCnt <= 0;
            weCnt     <= 0;
            badWe     <= 0;
        end else begin
            if (oDmaActive) activeCnt <= activeCnt + 1;
            if (oExtWe)     weCnt     <= weCnt + 1;
            if (oExtWe && oExtAddr >= 16'hFEA0 && oExtAddr <= 16'hFEFF)
                badWe <= badWe + 1;
        end
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge iClock);
            #1;
        end
    endtask

    task automatic cpuWrite(input logic [15:0] a, input logic [7:0] d,
                            output logic we, output logic [15:0] ea, output logic [7:0] ed);
        iCpuAddr = a;
        iCpuData = d;
        iCpuWe   = 1'b1;
        #1;
        we = oExtWe;
        ea = oExtAddr;
        ed = oExtData;
        @(posedge iClock);
        #1;
        iCpuWe = 1'b0;
    endtask

    task automatic cpuRead(input logic [15:0] a, output logic [7:0] d,
                           output logic re, output logic [15:0] ea);
        iCpuAddr        = a;
        iCpuReadRequest = 1'b1;
        #1;
        re = oExtRe;
        ea = oExtAddr;
        @(posedge iClock);
        #1;
        iCpuReadRequest = 1'b0;
        @(posedge iClock);
        #1;
        d = oCpuData;
    endtask

    task automatic waitIdle(input int bound);
        int n;
        n = 0;
        while (oDmaActive && n < bound) begin
            tick(1);
            n++;
        end
        checkVal("dma_done", {31'b0, oDmaActive}, 32'h0);
    endtask

    task automatic oamMismatch(input logic [7:0] srcHi, output int cnt);
        cnt = 0;
        for (int k = 0; k < 160; k++)
            if (mem[16'hFE00 + k] !== initVal({srcHi, k[7:0]}))
                cnt++;
    endtask

    logic        we, re;
    logic [15:0] ea;
    logic [7:0]  ed, d;
    int          mis;
    int          weBefore;

    initial begin
        iReset = 1'b1;
        iCpuAddr = 16'h0000;
        iCpuData = 8'h00;
        iCpuWe = 1'b0;
        iCpuReadRequest = 1'b0;
        memInit = 1'b1;
        cntClr = 1'b1;
        tick(1);
        memInit = 1'b0;
        cntClr = 1'b0;
        tick(2);

        checkVal("rst_cpudata", oCpuData, 8'h00);
        checkVal("rst_dma", oDmaActive, 1'b0);
        checkVal("rst_we", oExtWe, 1'b0);
        checkVal("rst_re", oExtRe, 1'b0);
        checkVal("rst_ie", oIE, 8'h00);
        checkVal("rst_if", oIF, 8'h00);
        iReset = 1'b0;

        // Boot ROM overlay
        cpuRead(16'h0000, d, re, ea);
        checkVal("boot0_data", d, 8'h31);
        checkVal("boot0_re", re, 1'b0);
        cpuRead(16'h0005, d, re, ea);
        checkVal("boot5_data", d, 8'h34);
        cpuRead(16'hFF50, d, re, ea);
        checkVal("ff50_on", d, 8'hFE);
        cpuWrite(16'hFF50, 8'h01, we, ea, ed);
        checkVal("ff50_we", we, 1'b0);
        cpuRead(16'hFF50, d, re, ea);
        checkVal("ff50_off", d, 8'hFF);
        cpuRead(16'h0000, d, re, ea);
        checkVal("ext0_re", re, 1'b1);
        checkVal("ext0_addr", ea, 16'h0000);
        checkVal("ext0_data", d, 8'hA5);

        // Echo write, normal read
        cpuWrite(16'hE123, 8'h5A, we, ea, ed);
        checkVal("echo_we", we, 1'b1);
        checkVal("echo_addr", ea, 16'hC123);
        checkVal("echo_wdata", ed, 8'h5A);
        cpuRead(16'hC123, d, re, ea);
        checkVal("c123_addr", ea, 16'hC123);
        checkVal("c123_data", d, 8'h5A);
        cpuRead(16'hE123, d, re, ea);
        checkVal("e123_data", d, 8'h5A);

        // Write and read strobes together act as a write only
        iCpuAddr = 16'hC200;
        iCpuData = 8'h3C;
        iCpuWe = 1'b1;
        iCpuReadRequest = 1'b1;
        #1;
        checkVal("wr_rd_we", oExtWe, 1'b1);
        checkVal("wr_rd_re", oExtRe, 1'b0);
        tick(1);
        iCpuWe = 1'b0;
        iCpuReadRequest = 1'b0;
        tick(1);
        checkVal("wr_rd_hold", oCpuData, 8'h5A);
        cpuRead(16'hC200, d, re, ea);
        checkVal("c200_data", d, 8'h3C);

        // Unusable region
        cpuRead(16'hFEA5, d, re, ea);
        checkVal("fea5_data", d, 8'hFF);
        checkVal("fea5_re", re, 1'b0);
        cpuWrite(16'hFEA5, 8'h12, we, ea, ed);
        checkVal("fea5_we", we, 1'b0);

        // Interrupt registers and HRAM
        cpuWrite(16'hFFFF, 8'h1F, we, ea, ed);
        cpuWrite(16'hFF0F, 8'h05, we, ea, ed);
        checkVal("ie_out", oIE, 8'h1F);
        checkVal("if_out", oIF, 8'h05);
        cpuRead(16'hFF0F, d, re, ea);
        checkVal("if_read", d, 8'hE5);
        cpuRead(16'hFFFF, d, re, ea);
        checkVal("ie_read", d, 8'h1F);
        cpuWrite(16'hFF80, 8'h11, we, ea, ed);
        cpuWrite(16'hFFFE, 8'h22, we, ea, ed);
        cpuRead(16'hFF80, d, re, ea);
        checkVal("hram_lo", d, 8'h11);
        cpuRead(16'hFFFE, d, re, ea);
        checkVal("hram_hi", d, 8'h22);

        // Full OAM DMA from C000
        memInit = 1'b1;
        cntClr = 1'b1;
        tick(1);
        memInit = 1'b0;
        cntClr = 1'b0;
        cpuWrite(16'hFF46, 8'hC0, we, ea, ed);
        checkVal("dma_active", oDmaActive, 1'b1);
        cpuRead(16'hFE00, d, re, ea);
        checkVal("dma_blocked_rd", d, 8'hFF);
        cpuWrite(16'hFF80, 8'h77, we, ea, ed);
        cpuRead(16'hFF80, d, re, ea);
        checkVal("dma_hram", d, 8'h77);
        cpuRead(16'hFF46, d, re, ea);
        checkVal("dma_reg", d, 8'hC0);
        waitIdle(1000);
        checkVal("dma_cycles", activeCnt, 320);
        checkVal("dma_writes", weCnt, 160);
        checkVal("dma_no_fea0", badWe, 0);
        oamMismatch(8'hC0, mis);
        checkVal("dma_oam", mis, 0);
        checkVal("dma_oam_last", mem[16'hFE9F], 8'h9F ^ 8'hC0 ^ 8'hA5);

        // Restart at byte 50 with source D0
        memInit = 1'b1;
        cntClr = 1'b1;
        tick(1);
        memInit = 1'b0;
        cntClr = 1'b0;
        cpuWrite(16'hFF46, 8'hC0, we, ea, ed);
        tick(100);
        cpuWrite(16'hFF46, 8'hD0, we, ea, ed);
        waitIdle(1000);
        checkVal("rst_dma_cycles", activeCnt, 421);
        checkVal("rst_dma_writes", weCnt, 210);
        oamMismatch(8'hD0, mis);
        checkVal("rst_dma_oam", mis, 0);
        cpuRead(16'hFF46, d, re, ea);
        checkVal("rst_dma_reg", d, 8'hD0);

        // Reset in the middle of a transfer (byte 80 read cycle)
        memInit = 1'b1;
        cntClr = 1'b1;
        tick(1);
        memInit = 1'b0;
        cntClr = 1'b0;
        cpuWrite(16'hFF46, 8'hC0, we, ea, ed);
        tick(160);
        weBefore = weCnt;
        checkVal("abort_pre_writes", weBefore, 80);
        iReset = 1'b1;
        #1;
        checkVal("abort_we_now", oExtWe, 1'b0);
        checkVal("abort_re_now", oExtRe, 1'b0);
        tick(1);
        checkVal("abort_active", oDmaActive, 1'b0);
        checkVal("abort_we_next", oExtWe, 1'b0);
        tick(1);
        iReset = 1'b0;
        tick(3);
        checkVal("abort_writes", weCnt, 80);
        checkVal("abort_oam79", mem[16'hFE4F], 8'h2A);
        checkVal("abort_oam80", mem[16'hFE50], 8'h00);
        checkVal("abort_ie", oIE, 8'h00);
        checkVal("abort_cpudata", oCpuData, 8'h00);
        cpuRead(16'hFF50, d, re, ea);
        checkVal("abort_booten", d, 8'hFE);
        cpuRead(16'h0000, d, re, ea);
        checkVal("abort_boot0", d, 8'h31);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gb_mcu.md
GB_MCU -- requirements
Module: gb_mcu

Interface
REQ-001 iClock  in  1  system clock; all state updates on rising edge.
REQ-002 iReset  in  1  reset, synchronous, active-high.
REQ-003 iCpuAddr  in  16  CPU bus address.
REQ-004 iCpuData  in  8  CPU write data.
REQ-005 iCpuWe  in  1  CPU write strobe, one cycle per write.
REQ-006 iCpuReadRequest  in  1  CPU read strobe, one cycle per read.
REQ-007 oCpuData  out  8  registered read data returned to CPU.
REQ-008 oExtAddr/oExtData/oExtWe/oExtRe  out  16/8/1/1  external bus to synchronous memories: ROM, VRAM, ext RAM, WRAM, OAM, IO.
REQ-009 iExtData  in  8  external read data, valid the cycle after oExtRe.
REQ-010 oBootAddr  out  8; iBootData  in  8  boot ROM port, same 1-cycle latency.
REQ-011 oDmaActive  out  1  OAM DMA in progress.
REQ-012 oIE/oIF  out  8/8  interrupt enable (FFFF) and flag (FF0F) registers.

Function
REQ-013 Address decode SHALL be:
- 0000-00FF boot ROM while boot enabled, else external.
- 0100-DFFF external.
- E000-FDFF echo, forwarded as address-2000h.
- FE00-FE9F external (OAM).
- FEA0-FEFF unusable: reads FFh, writes ignored.
- FF0F, FF46, FF50, FF80-FFFE (HRAM, 127x8), FFFF internal.
- Remaining FF00-FF7F external.
REQ-014 Read latency SHALL be 2 for every region: request in cycle N -> oCpuData updated at edge ending cycle N+1, held until next read completes.
REQ-015 Writes SHALL take effect at the edge ending the iCpuWe cycle; external writes drive oExtWe for exactly that cycle.
REQ-016 iCpuWe and iCpuReadRequest high together SHALL be treated as write only.
REQ-017 FF50 write of any nonzero value SHALL clear boot enable, sticky until reset; reads return {7'h7F, ~bootEn}.
REQ-018 FF0F/FFFF SHALL be read/write 8-bit registers; FF0F reads return {3'b111, IF[4:0]}.
REQ-019 Write of value XX to FF46 SHALL start OAM DMA:
- Source XX00-XX9F (XX >= E0 remapped via echo rule), destination FE00-FE9F.
- FF46 reads return the last value written.
REQ-020 DMA state machine SHALL have states IDLE -> RD -> WR -> RD ... -> IDLE:
- RD issues oExtRe at the source address.
- WR issues oExtWe at the destination with iExtData.
- 160 bytes, 320 cycles.
- oDmaActive high from the cycle after the FF46 write through the final WR cycle.
REQ-021 A write to FF46 during DMA SHALL restart the transfer at byte 0 with the new source.
REQ-022 While oDmaActive, DMA SHALL own the external bus: CPU reads outside FF80-FFFE return FFh, CPU writes outside FF80-FFFE are dropped, HRAM and FF46 remain accessible.
REQ-023 The DMA byte counter SHALL be 8 bits and terminate at 9Fh, with no wrap into FEA0.
REQ-024 Outputs SHALL be idle when no access is in progress: oExtWe=0, oExtRe=0.

Reset
REQ-025 iReset SHALL set oCpuData=00h, bootEn=1, IE=00h, IF=00h, FF46 reg=00h, DMA=IDLE, oDmaActive=0, oExtWe=0, oExtRe=0, and clear the read pipeline.
REQ-026 iReset mid-DMA SHALL abort within the reset cycle; no further oExtWe.
REQ-027 HRAM contents SHALL be undefined after reset (not cleared).

Structure
REQ-028 Region base/limit constants, IO register addresses (FF0F, FF46, FF50, FFFF) and DMA state encodings SHALL live in the shared definitions include.
REQ-029 DMA engine SHALL be sub-module gb_mcu_dma (state, counter, bus request); decode, HRAM, registers and read pipeline stay in gb_mcu.

Verification
REQ-030 After reset, read 0000 with iBootData=31h -> oCpuData=31h two cycles later; write 01h to FF50, read 0000 -> oExtRe with oExtAddr=0000, returns iExtData.
REQ-031 Write 5Ah to E123, read C123 -> oExtWe with oExtAddr=C123 and data 5Ah; read returns 5Ah from memory model.
REQ-032 Write C0h to FF46 -> oDmaActive high 320 cycles; OAM model FE00-FE9F equals C000-C09F; read FE00 during DMA returns FFh; HRAM FF80 write/read 77h works during DMA.
REQ-033 Restart: write C0h to FF46, at byte 50 write D0h -> 320 further cycles, final OAM equals D000-D09F.
REQ-034 Read FEA5 -> FFh, no oExtRe; write FFFF=1Fh, FF0F=05h -> oIE=1Fh, oIF=05h, read FF0F=E5h.
REQ-035 iReset asserted at DMA byte 80 -> oDmaActive=0 and no oExtWe the next cycle; bootEn=1, IE=00h.
